// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with a credit-limited prefetch queue feeding IF_ID.
//   clk, rst (async, active-low)
//   imem_req_valid/ready/addr   : in-order instruction requests, one per handshake
//   imem_resp_valid/data        : in-order responses, never back-pressured
//   stall, redirect_valid/pc    : hazard hold and branch redirect (redirect wins)
//   if_valid/instruction/pc     : queue head presented to IF_ID
//   outstanding                 : requests in flight
module fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] PC_STEP     = 64'd4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [63:0]                  imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [31:0]                  imem_resp_data,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         if_valid,
    output logic [31:0]                  if_instruction,
    output logic [63:0]                  if_pc,
    output logic [$clog2(QUEUE_DEPTH):0] outstanding
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    logic [63:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [63:0]   pc_mem  [QUEUE_DEPTH];
    logic [31:0]   ins_mem [QUEUE_DEPTH];
    logic          fire, push, pop;
    always_comb begin
        target         = redirect_pc & ~64'd3;
        // credits: queued entries plus in-flight requests never exceed the queue size
        imem_req_valid = rst && !redirect_valid &&
                         (({1'b0, count_q} + {1'b0, out_q}) < (CW + 1)'(QUEUE_DEPTH));
        imem_req_addr  = fetch_pc_q;
        fire           = imem_req_valid && imem_req_ready;
        // a response arriving with a redirect, or while stale ones are pending, is discarded
        push           = imem_resp_valid && !redirect_valid && drop_q == '0;
        if_valid       = count_q != '0;
        pop            = if_valid && !stall && !redirect_valid;
        if_pc          = if_valid ? pc_mem[rd_ptr_q] : '0;
        if_instruction = if_valid ? ins_mem[rd_ptr_q] : '0;
        outstanding    = out_q;
        out_d          = out_q + CW'(fire) - CW'(imem_resp_valid);
        drop_d         = redirect_valid ? out_q - CW'(imem_resp_valid)
                                        : drop_q - CW'(imem_resp_valid && drop_q != '0);
        count_d        = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d       = redirect_valid ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d       = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
        fetch_pc_d     = redirect_valid ? target : fetch_pc_q + (fire ? PC_STEP : 64'd0);
        resp_pc_d      = redirect_valid ? target : resp_pc_q + (push ? PC_STEP : 64'd0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end
    // queue storage needs no reset: entries are only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= resp_pc_q;
            ins_mem[wr_ptr_q] <= imem_resp_data;
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction Fetch stage feeding the IF_ID pipeline register. It owns the architectural fetch PC and issues in-order requests to a variable-latency instruction memory port. Returned instructions are buffered in a small prefetch queue and presented to IF_ID as {pc, instruction}. The stage honours the hazard-unit stall and performs branch redirects, discarding any stale in-flight responses.

Parameters:
RESET_PC, 64'h0, fetch address after reset
QUEUE_DEPTH, 4, prefetch queue entries (power of 2, >=2)
PC_STEP, 4, byte increment per instruction

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  byte address of requested instruction
imem_resp_valid  in  1  response valid (in order, one per accepted request, never back-pressured)
imem_resp_data  in  32  returned instruction
stall  in  1  hazard unit: IF_ID holds, head not consumed
redirect_valid  in  1  branch taken/flush, single-cycle pulse
redirect_pc  in  64  new fetch target
if_valid  out  1  head entry valid
if_instruction  out  32  head instruction
if_pc  out  64  PC of head instruction
outstanding  out  $clog2(QUEUE_DEPTH)+1  requests in flight (debug/verification)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
- During reset: if_valid=0, if_instruction=0, if_pc=0, imem_req_valid=0.
- Reset may assert mid-transaction. Responses for requests issued before reset are the memory's responsibility; the stage treats post-reset state as fresh.
- Issue:
  - imem_req_valid = !redirect_valid && (count + outstanding < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += PC_STEP, outstanding++.
  - The credit rule guarantees the queue never overflows.
- Response:
  - If drop_cnt>0: discard, drop_cnt--, outstanding--.
  - Else: push {resp_pc, imem_resp_data}, resp_pc += PC_STEP, outstanding--.
- Output:
  - if_valid = count!=0; head is shown combinationally from queue storage.
  - Pop when if_valid && !stall && !redirect_valid.
  - Push and pop in the same cycle leave count unchanged.
  - Earliest latency: response at cycle N gives if_valid at N+1.
- Stall: head held stable. Issue continues until credits are exhausted (queue full + in flight = QUEUE_DEPTH), then imem_req_valid=0.
- Redirect (highest priority):
  - Queue flushed (count=0).
  - fetch_pc = resp_pc = {redirect_pc[63:2],2'b00}.
  - No request issued that cycle.
  - drop_cnt = outstanding - (resp_valid ? 1 : 0), with outstanding decremented for a same-cycle response. The same-cycle response is discarded regardless of drop_cnt.
  - First request to the new target is issued the next cycle.
- Back-to-back redirects: each reloads the PCs. drop_cnt is recomputed from the current outstanding, so no stale response is ever enqueued.
- Arithmetic: PC adds are 64-bit modulo 2^64, so fetch_pc wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 silently.
- Queue pointers are log2(QUEUE_DEPTH) bits wrapping naturally. count is one bit wider.

Test Plan:
1. Reset release, memory ready=1, fixed 1-cycle latency, RESET_PC=0 -> requests to 0,4,8,...; if_pc sequence 0,4,8 with matching instructions; if_valid=1 from the 3rd cycle after reset release; no gaps.
2. stall=1 held 10 cycles with QUEUE_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; head stays if_pc=0. After stall drops, entries 0,4,8,12 are delivered in order.
3. 3-cycle latency, redirect_valid to 0x100 with 2 outstanding -> queue flushed, next 2 responses dropped, first delivered if_pc=0x100; no entry with pc<0x100 appears afterwards.
4. Redirect in the same cycle as a resp_valid and a pop -> response discarded, no pop effect, drop_cnt = outstanding-1. Bench checks all subsequent if_pc values equal the redirect target onward.
5. Redirect with redirect_pc=0x203 -> fetch from 0x200.
6. RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> addresses ...FFF8, ...FFFC, 0x0.
7. Assert rst low mid-stall with 2 in flight -> outputs zero immediately (async). After release, fetch restarts at RESET_PC with outstanding=0.
